program_sequencer: RTL and testbench

Parametrised successor to the 6-bit program counter. It holds the fetch address and advances it by the instruction length decoded from the current opcode. Adds absolute jump, call/return through an internal return-address stack, stall, and sticky stack error flags. Sits between instruction fetch and the control unit; the control unit drives all control strobes.

---
 rtl/program_sequencer_pkg.sv | 21 ++
 rtl/instr_length_decoder.sv | 22 ++
 rtl/program_sequencer.sv | 123 ++++++++++++
 tb/tb_program_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared constants and helpers for the program sequencer and fetch unit.
// Contents: 2-bit instruction length codes and the code -> length mapping.
package program_sequencer_pkg;

  localparam logic [1:0] LEN_CODE_0OP = 2'b00;
  localparam logic [1:0] LEN_CODE_1OP = 2'b01;
  localparam logic [1:0] LEN_CODE_2OP = 2'b10;

  // Instruction length in words (1..3) for a 2-bit length code; 2'b11 also means two operands.
  function automatic logic [1:0] len_from_code(input logic [1:0] code);
    logic [1:0] len;
    case (code)
      LEN_CODE_0OP: len = 2'd1;
      LEN_CODE_1OP: len = 2'd2;
      LEN_CODE_2OP: len = 2'd3;
      default:      len = 2'd3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_length_decoder.sv
// Combinational opcode -> instruction length decoder, shared with the fetch unit.
// Ports:
//   opcode : current instruction; the top two bits carry the length code
//   len_c  : instruction length in words (1, 2 or 3), combinational
module instr_length_decoder
  import program_sequencer_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 8
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [1:0]              len_c
);

  assign len_c = len_from_code(opcode[OPCODE_WIDTH-1 -: 2]);

  // The low opcode bits carry no length information.
  if (OPCODE_WIDTH > 2) begin : g_low_bits
    logic unused_low_bits;
    assign unused_low_bits = ^opcode[OPCODE_WIDTH-3:0];
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetch address register advanced by decoded instruction
// length, with absolute jump, call/return through an internal LIFO
// return-address stack, stall, and sticky stack error flags.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   pc_load, opcode       : advance pc by the length of opcode
//   stall                 : freeze all state
//   jump, jump_target     : absolute jump (target also used by call)
//   call, ret             : push return address and jump / pop into pc
//   pc                    : current fetch address
//   stack_count           : valid stack entries
//   stack_full/empty      : stack occupancy status
//   stack_overflow/underflow : sticky error flags, cleared only by reset
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 6,
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pc_load,
  input  logic [OPCODE_WIDTH-1:0]      opcode,
  input  logic                         stall,
  input  logic                         jump,
  input  logic [PC_WIDTH-1:0]          jump_target,
  input  logic                         call,
  input  logic                         ret,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [$clog2(STACK_DEPTH):0] stack_count,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [1:0]          instr_len;
  logic [PC_WIDTH-1:0] seq_addr;
  logic [PTR_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    top_idx;

  logic [PC_WIDTH-1:0] pc_next;
  logic [CNT_W-1:0]    count_next;
  logic                push;
  logic                ovf_next;
  logic                unf_next;

  instr_length_decoder #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_len_dec (
    .opcode(opcode),
    .len_c (instr_len)
  );

  // Sequential address doubles as the call return address; wraps mod 2^PC_WIDTH.
  assign seq_addr = pc + PC_WIDTH'(instr_len);
  // Write pointer equals stack_count; truncation when full is harmless since push is blocked.
  assign wr_idx   = stack_count[PTR_W-1:0];
  assign top_idx  = PTR_W'(stack_count - CNT_W'(1));

  // Next-state selection: stall > ret > call > jump > pc_load > hold.
  always_comb begin
    pc_next    = pc;
    count_next = stack_count;
    push       = 1'b0;
    ovf_next   = stack_overflow;
    unf_next   = stack_underflow;
    if (!stall) begin
      if (ret) begin
        if (!stack_empty) begin
          pc_next    = stack_mem[top_idx];
          count_next = stack_count - CNT_W'(1);
        end else begin
          unf_next = 1'b1;
        end
      end else if (call) begin
        if (!stack_full) begin
          push       = 1'b1;
          count_next = stack_count + CNT_W'(1);
        end else begin
          ovf_next = 1'b1;
        end
        pc_next = jump_target;
      end else if (jump) begin
        pc_next = jump_target;
      end else if (pc_load) begin
        pc_next = seq_addr;
      end
    end
  end

  // Control state; full/empty are registered alongside the count they decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc              <= '0;
      stack_count     <= '0;
      stack_full      <= 1'b0;
      stack_empty     <= 1'b1;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      pc              <= pc_next;
      stack_count     <= count_next;
      stack_full      <= (count_next == CNT_W'(STACK_DEPTH));
      stack_empty     <= (count_next == '0);
      stack_overflow  <= ovf_next;
      stack_underflow <= unf_next;
    end
  end

  // Stack storage carries no reset; a reset push is suppressed so the stack is discarded.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      stack_mem[wr_idx] <= seq_addr;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_program_sequencer;

  localparam int PW = 6;
  localparam int OW = 8;
  localparam int SD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          pc_load;
  logic [OW-1:0] opcode;
  logic          stall;
  logic          jump;
  logic [PW-1:0] jump_target;
  logic          call;
  logic          ret;
  logic [PW-1:0] pc;
  logic [2:0]    stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_overflow;
  logic          stack_underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  program_sequencer #(.PC_WIDTH(PW), .OPCODE_WIDTH(OW), .STACK_DEPTH(SD)) dut (
    .clock(clock), .reset(reset), .pc_load(pc_load), .opcode(opcode),
    .stall(stall), .jump(jump), .jump_target(jump_target), .call(call),
    .ret(ret), .pc(pc), .stack_count(stack_count), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  function automatic int len_of(input logic [OW-1:0] op);
    int code;
    code = int'(op[OW-1:OW-2]);
    if (code == 0) return 1;
    if (code == 1) return 2;
    return 3;
  endfunction

  task automatic idle();
    reset = 1'b0; pc_load = 1'b0; stall = 1'b0; jump = 1'b0;
    call = 1'b0; ret = 1'b0; opcode = '0; jump_target = '0;
  endtask

  // Advance the model by the current inputs, then clock the DUT and settle.
  task automatic tick();
    int ra;
    if (reset) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_unf = 1;
    end else if (call) begin
      ra = (m_pc + len_of(opcode)) % (1 << PW);
      if (m_stk.size() < SD) m_stk.push_back(ra);
      else m_ovf = 1;
      m_pc = int'(jump_target);
    end else if (jump) begin
      m_pc = int'(jump_target);
    end else if (pc_load) begin
      m_pc = (m_pc + len_of(opcode)) % (1 << PW);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; tick(); tick(); reset = 1'b0;
    checks++; if (pc !== 6'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (stack_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", stack_count); end
    checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin failures++; $display("FAIL reset_status got empty=%b full=%b exp empty=1 full=0", stack_empty, stack_full); end
    checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", stack_overflow, stack_underflow); end
  endtask

  task automatic test_pc_load();
    logic [OW-1:0] ops [3];
    int exp_pc [3];
    ops[0] = 8'b01111000; ops[1] = 8'b10000011; ops[2] = 8'b11111111;
    exp_pc[0] = 2; exp_pc[1] = 5; exp_pc[2] = 8;
    idle();
    for (int i = 0; i < 3; i++) begin
      pc_load = 1'b1; opcode = ops[i]; tick();
      checks++; if (int'(pc) !== exp_pc[i]) begin failures++; $display("FAIL pc_load_%0d got=%0d exp=%0d", i, pc, exp_pc[i]); end
    end
    idle();
  endtask

  task automatic test_wrap_stall();
    idle(); jump = 1'b1; jump_target = 6'd62; tick();
    idle(); pc_load = 1'b1; opcode = 8'b10101010; tick();
    checks++; if (pc !== 6'd1) begin failures++; $display("FAIL wrap got=%0d exp=1", pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 6'd1) begin failures++; $display("FAIL stall_%0d got=%0d exp=1", i, pc); end
    end
    idle();
  endtask

  task automatic test_call_ret();
    idle(); jump = 1'b1; jump_target = 6'd10; tick();
    idle(); call = 1'b1; opcode = 8'b01000000; jump_target = 6'd40; tick();
    checks++; if (pc !== 6'd40 || stack_count !== 3'd1) begin failures++; $display("FAIL call got pc=%0d cnt=%0d exp pc=40 cnt=1", pc, stack_count); end
    idle(); ret = 1'b1; tick();
    checks++; if (pc !== 6'd12 || stack_empty !== 1'b1) begin failures++; $display("FAIL ret got pc=%0d empty=%b exp pc=12 empty=1", pc, stack_empty); end
    idle();
  endtask

  task automatic test_overflow();
    int exp_ret [4];
    // Starting at pc=12 with 1-word opcodes: returns are 13, 30+1, 31+1, 32+1.
    exp_ret[0] = 33; exp_ret[1] = 32; exp_ret[2] = 31; exp_ret[3] = 13;
    for (int i = 0; i < 4; i++) begin
      idle(); call = 1'b1; opcode = 8'h00; jump_target = PW'(30 + i); tick();
    end
    checks++; if (stack_full !== 1'b1 || stack_count !== 3'd4) begin failures++; $display("FAIL fill got full=%b cnt=%0d exp full=1 cnt=4", stack_full, stack_count); end
    idle(); call = 1'b1; jump_target = 6'd20; tick();
    checks++; if (pc !== 6'd20 || stack_count !== 3'd4 || stack_overflow !== 1'b1) begin failures++; $display("FAIL overflow got pc=%0d cnt=%0d ovf=%b exp pc=20 cnt=4 ovf=1", pc, stack_count, stack_overflow); end
    for (int i = 0; i < 4; i++) begin
      idle(); ret = 1'b1; tick();
      checks++; if (int'(pc) !== exp_ret[i]) begin failures++; $display("FAIL lifo_%0d got=%0d exp=%0d", i, pc, exp_ret[i]); end
    end
    checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL lifo_empty got=%b exp=1", stack_empty); end
    idle();
  endtask

  task automatic test_underflow();
    idle(); jump = 1'b1; jump_target = 6'd7; tick();
    idle(); ret = 1'b1; tick();
    checks++; if (pc !== 6'd7 || stack_underflow !== 1'b1) begin failures++; $display("FAIL underflow got pc=%0d unf=%b exp pc=7 unf=1", pc, stack_underflow); end
    idle(); pc_load = 1'b1; opcode = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (pc !== 6'd10 || stack_underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got pc=%0d unf=%b exp pc=10 unf=1", pc, stack_underflow); end
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (stack_underflow !== 1'b0 || stack_overflow !== 1'b0) begin failures++; $display("FAIL flag_clear got unf=%b ovf=%b exp 0 0", stack_underflow, stack_overflow); end
    idle();
  endtask

  task automatic test_priority();
    idle(); call = 1'b1; opcode = 8'h00; jump_target = 6'd25; tick();
    idle(); ret = 1'b1; call = 1'b1; jump = 1'b1; jump_target = 6'd50; pc_load = 1'b1; tick();
    checks++; if (pc !== 6'd1 || stack_count !== 3'd0 || stack_overflow !== 1'b0) begin failures++; $display("FAIL priority got pc=%0d cnt=%0d ovf=%b exp pc=1 cnt=0 ovf=0", pc, stack_count, stack_overflow); end
    idle(); call = 1'b1; jump_target = 6'd40; tick();
    call = 1'b1; reset = 1'b1; jump_target = 6'd33; tick();
    checks++; if (pc !== 6'd0 || stack_count !== 3'd0 || stack_empty !== 1'b1) begin failures++; $display("FAIL reset_in_call got pc=%0d cnt=%0d empty=%b exp pc=0 cnt=0 empty=1", pc, stack_count, stack_empty); end
    idle();
  endtask

  task automatic test_random();
    int exp_cnt;
    idle();
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) < 2);
      stall       = ($urandom_range(0, 99) < 10);
      ret         = ($urandom_range(0, 99) < 20);
      call        = ($urandom_range(0, 99) < 22);
      jump        = ($urandom_range(0, 99) < 10);
      pc_load     = ($urandom_range(0, 99) < 60);
      opcode      = OW'($urandom);
      jump_target = PW'($urandom);
      tick();
      exp_cnt = m_stk.size();
      checks++; if (int'(pc) !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%0d exp=%0d", n, pc, m_pc); end
      checks++; if (int'(stack_count) !== exp_cnt) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, stack_count, exp_cnt); end
      checks++; if (stack_full !== (exp_cnt == SD) || stack_empty !== (exp_cnt == 0)) begin failures++; $display("FAIL rnd_status cyc=%0d got full=%b empty=%b exp cnt=%0d", n, stack_full, stack_empty, exp_cnt); end
      checks++; if (stack_overflow !== m_ovf || stack_underflow !== m_unf) begin failures++; $display("FAIL rnd_flags cyc=%0d got ovf=%b unf=%b exp ovf=%b unf=%b", n, stack_overflow, stack_underflow, m_ovf, m_unf); end
    end
    idle();
  endtask

  initial begin
    idle();
    m_pc = 0; m_ovf = 0; m_unf = 0;
    @(negedge clock);
    test_reset();
    test_pc_load();
    test_wrap_stall();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
